// File: rtl/pong_pkg.sv
// Shared definitions for the pong match controller: FSM encoding and default geometry/score limits.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_MENU  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam int WIN_SCORE_DEF = 3;
    localparam int Y_MAX_DEF     = 420;
    localparam int Y_CENTER_DEF  = 210;
    localparam int Y_W           = 9;
    localparam int SCORE_W       = 4;

endpackage

// File: rtl/bar_req_buf.sv
// One paddle: buffers the latest clamped y request and applies it on the next frame tick.
module bar_req_buf
    import pong_pkg::*;
#(
    parameter int Y_MAX    = Y_MAX_DEF,
    parameter int Y_CENTER = Y_CENTER_DEF
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           center_i,
    input  logic           tick_i,
    input  logic           wr_i,
    input  logic [Y_W-1:0] y_i,
    output logic [Y_W-1:0] y_o,
    output logic           refresh_o
);

    localparam logic [Y_W-1:0] YMAX_C = Y_W'(Y_MAX);
    localparam logic [Y_W-1:0] YCEN_C = Y_W'(Y_CENTER);

    function automatic logic [Y_W-1:0] clamp_y(input logic [Y_W-1:0] y);
        return (y > YMAX_C) ? YMAX_C : y;
    endfunction

    logic [Y_W-1:0] y_q, y_d;
    logic [Y_W-1:0] pend_val_q, pend_val_d;
    logic           pend_q, pend_d;
    logic           refresh_q, refresh_d;

    always_comb begin
        y_d        = y_q;
        pend_val_d = pend_val_q;
        pend_d     = pend_q;
        refresh_d  = 1'b0;
        if (center_i) begin
            y_d    = YCEN_C;
            pend_d = 1'b0;
        end else begin
            if (tick_i && pend_q) begin
                y_d       = pend_val_q;
                refresh_d = 1'b1;
                pend_d    = 1'b0;
            end
            // A write coinciding with the tick lands after the copy, so it waits for the next tick.
            if (wr_i) begin
                pend_val_d = clamp_y(y_i);
                pend_d     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            y_q       <= YCEN_C;
            pend_q    <= 1'b0;
            refresh_q <= 1'b0;
        end else begin
            y_q       <= y_d;
            pend_q    <= pend_d;
            refresh_q <= refresh_d;
        end
        pend_val_q <= pend_val_d;
    end

    assign y_o       = y_q;
    assign refresh_o = refresh_q;

endmodule

// File: rtl/pong_match_ctrl.sv
// Match sequencing for pong: menu, serve pause, play, scoring and game over,
// plus the custom-instruction path that positions both paddles.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = WIN_SCORE_DEF,
    parameter int SERVE_FRAMES = 60,
    parameter int Y_MAX        = Y_MAX_DEF,
    parameter int Y_CENTER     = Y_CENTER_DEF
) (
    input  logic           CLK,
    input  logic           i_rst,
    input  logic           i_frame_tick,
    input  logic           i_start,
    input  logic           ci_valid,
    input  logic [31:0]    ci_dataa,
    output logic           ci_done,
    input  logic           i_point_p1,
    input  logic           i_point_p2,
    output logic           enable_pong,
    output logic           ball_hold,
    output logic           serve_dir,
    output logic [Y_W-1:0] bar1_y,
    output logic [Y_W-1:0] bar2_y,
    output logic           refresh_bar1,
    output logic           refresh_bar2,
    output logic [31:0]    result
);

    localparam logic [7:0]         LAST_TICK = 8'(SERVE_FRAMES - 1);
    localparam logic [SCORE_W-1:0] WIN_C     = SCORE_W'(WIN_SCORE);

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
        return (s == {SCORE_W{1'b1}}) ? s : s + 1'b1;
    endfunction

    state_e             state_q, state_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic               dir_q, dir_d;
    logic [7:0]         result_q;
    logic               done_q;
    logic               new_match;
    logic               bar_wr_ok;
    logic               unused_dataa;

    assign unused_dataa = ^ci_dataa[31:10];

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        score1_d    = score1_q;
        score2_d    = score2_q;
        dir_d       = dir_q;
        new_match   = 1'b0;
        enable_pong = 1'b0;
        ball_hold   = 1'b1;
        case (state_q)
            ST_MENU, ST_OVER: begin
                if (i_start) begin
                    new_match = 1'b1;
                    score1_d  = '0;
                    score2_d  = '0;
                    dir_d     = 1'b0;
                    cnt_d     = '0;
                    state_d   = ST_SERVE;
                end
            end
            ST_SERVE: begin
                enable_pong = 1'b1;
                if (i_frame_tick) begin
                    if (cnt_q == LAST_TICK) begin
                        cnt_d   = '0;
                        state_d = ST_PLAY;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            ST_PLAY: begin
                enable_pong = 1'b1;
                ball_hold   = 1'b0;
                // p1 wins a simultaneous pulse; next serve goes toward whoever lost the point.
                if (i_point_p1) begin
                    score1_d = sat_inc(score1_q);
                    dir_d    = 1'b1;
                    state_d  = ST_POINT;
                end else if (i_point_p2) begin
                    score2_d = sat_inc(score2_q);
                    dir_d    = 1'b0;
                    state_d  = ST_POINT;
                end
            end
            ST_POINT: begin
                enable_pong = 1'b1;
                if (score1_q >= WIN_C || score2_q >= WIN_C) state_d = ST_OVER;
                else                                        state_d = ST_SERVE;
            end
            default: state_d = ST_MENU;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (i_rst) begin
            state_q  <= ST_MENU;
            cnt_q    <= '0;
            score1_q <= '0;
            score2_q <= '0;
            dir_q    <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            dir_q    <= dir_d;
            result_q <= {score2_d, score1_d};
            done_q   <= ci_valid;
        end
    end

    assign bar_wr_ok = ci_valid && (state_q == ST_SERVE || state_q == ST_PLAY);

    bar_req_buf #(.Y_MAX(Y_MAX), .Y_CENTER(Y_CENTER)) u_bar1 (
        .clk_i     (CLK),
        .rst_i     (i_rst),
        .center_i  (new_match),
        .tick_i    (i_frame_tick),
        .wr_i      (bar_wr_ok && ci_dataa[9]),
        .y_i       (ci_dataa[8:0]),
        .y_o       (bar1_y),
        .refresh_o (refresh_bar1)
    );

    bar_req_buf #(.Y_MAX(Y_MAX), .Y_CENTER(Y_CENTER)) u_bar2 (
        .clk_i     (CLK),
        .rst_i     (i_rst),
        .center_i  (new_match),
        .tick_i    (i_frame_tick),
        .wr_i      (bar_wr_ok && !ci_dataa[9]),
        .y_i       (ci_dataa[8:0]),
        .y_o       (bar2_y),
        .refresh_o (refresh_bar2)
    );

    assign serve_dir = dir_q;
    assign ci_done   = done_q;
    assign result    = {24'b0, result_q};

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Bench for pong_match_ctrl: vector tables plus scripted match sequences, checked via an expectation queue.
`timescale 1ns/1ps
module tb_pong_match_ctrl;

    localparam int SF = 60;

    logic        CLK = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_frame_tick = 1'b0;
    logic        i_start = 1'b0;
    logic        ci_valid = 1'b0;
    logic [31:0] ci_dataa = '0;
    logic        ci_done;
    logic        i_point_p1 = 1'b0;
    logic        i_point_p2 = 1'b0;
    logic        enable_pong;
    logic        ball_hold;
    logic        serve_dir;
    logic [8:0]  bar1_y;
    logic [8:0]  bar2_y;
    logic        refresh_bar1;
    logic        refresh_bar2;
    logic [31:0] result;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    string       nm_q[$];

    typedef struct {
        string       nm;
        bit          rst, st, tk, a, b, cv;
        logic [31:0] d;
        logic [31:0] e;
    } vec_t;

    vec_t menu_tbl[$];
    vec_t bar_tbl[$];

    pong_match_ctrl dut (
        .CLK          (CLK),
        .i_rst        (i_rst),
        .i_frame_tick (i_frame_tick),
        .i_start      (i_start),
        .ci_valid     (ci_valid),
        .ci_dataa     (ci_dataa),
        .ci_done      (ci_done),
        .i_point_p1   (i_point_p1),
        .i_point_p2   (i_point_p2),
        .enable_pong  (enable_pong),
        .ball_hold    (ball_hold),
        .serve_dir    (serve_dir),
        .bar1_y       (bar1_y),
        .bar2_y       (bar2_y),
        .refresh_bar1 (refresh_bar1),
        .refresh_bar2 (refresh_bar2),
        .result       (result)
    );

    always #5 CLK = ~CLK;

    initial begin
        #1ms;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1);
    end

    function automatic logic [31:0] pk(input bit en, input bit hold, input bit dir,
                                       input bit done, input bit rf1, input bit rf2,
                                       input logic [8:0] b1, input logic [8:0] b2,
                                       input logic [7:0] res);
        return {en, hold, dir, done, rf1, rf2, b1, b2, res};
    endfunction

    function automatic logic [31:0] obs();
        return pk(enable_pong, ball_hold, serve_dir, ci_done, refresh_bar1, refresh_bar2,
                  bar1_y, bar2_y, result[7:0]);
    endfunction

    function automatic vec_t mkv(input string nm, input bit rst, input bit st, input bit tk,
                                 input bit a, input bit b, input bit cv,
                                 input logic [31:0] d, input logic [31:0] e);
        vec_t v;
        v.nm = nm; v.rst = rst; v.st = st; v.tk = tk;
        v.a = a; v.b = b; v.cv = cv; v.d = d; v.e = e;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, and compare once the edge has passed.
    task automatic cyc(input string nm, input bit r, input bit st, input bit tk,
                       input bit a, input bit b, input bit cv,
                       input logic [31:0] d, input logic [31:0] e);
        exp_q.push_back(e);
        nm_q.push_back(nm);
        i_rst = r; i_start = st; i_frame_tick = tk;
        i_point_p1 = a; i_point_p2 = b; ci_valid = cv; ci_dataa = d;
        @(posedge CLK);
        #1;
        i_rst = 1'b0; i_start = 1'b0; i_frame_tick = 1'b0;
        i_point_p1 = 1'b0; i_point_p2 = 1'b0; ci_valid = 1'b0; ci_dataa = '0;
        check(nm_q.pop_front(), obs(), exp_q.pop_front());
    endtask

    task automatic run_vec(input vec_t v);
        cyc(v.nm, v.rst, v.st, v.tk, v.a, v.b, v.cv, v.d, v.e);
    endtask

    task automatic serve_to_play(input bit dir, input logic [7:0] res,
                                 input logic [8:0] b1, input logic [8:0] b2);
        for (int i = 1; i <= SF; i++) begin
            cyc("serve_tick", 0, 0, 1, 0, 0, 0, 0, pk(1, (i == SF) ? 1'b0 : 1'b1, dir, 0, 0, 0, b1, b2, res));
            cyc("serve_gap", 0, 0, 0, 0, 0, 0, 0, pk(1, (i == SF) ? 1'b0 : 1'b1, dir, 0, 0, 0, b1, b2, res));
        end
    endtask

    initial begin
        menu_tbl.push_back(mkv("rst_prio",     1, 1, 1, 1, 0, 1, 32'h3FF, pk(0,1,0,0,0,0,210,210,8'h00)));
        menu_tbl.push_back(mkv("rst_hold",     1, 0, 0, 0, 0, 0, 32'h0,   pk(0,1,0,0,0,0,210,210,8'h00)));
        menu_tbl.push_back(mkv("menu_tick",    0, 0, 1, 0, 0, 0, 32'h0,   pk(0,1,0,0,0,0,210,210,8'h00)));
        menu_tbl.push_back(mkv("menu_ci_done", 0, 0, 0, 0, 0, 1, 32'h32C, pk(0,1,0,1,0,0,210,210,8'h00)));
        menu_tbl.push_back(mkv("menu_no_pend", 0, 0, 1, 0, 0, 0, 32'h0,   pk(0,1,0,0,0,0,210,210,8'h00)));
        menu_tbl.push_back(mkv("menu_pt_ign",  0, 0, 0, 1, 1, 0, 32'h0,   pk(0,1,0,0,0,0,210,210,8'h00)));
        menu_tbl.push_back(mkv("start_serve",  0, 1, 1, 0, 0, 0, 32'h0,   pk(1,1,0,0,0,0,210,210,8'h00)));

        bar_tbl.push_back(mkv("ci_done_b1",   0, 0, 0, 0, 0, 1, 32'h3FF, pk(1,0,0,1,0,0,210,210,8'h00)));
        bar_tbl.push_back(mkv("b1_clamp",     0, 0, 1, 0, 0, 0, 32'h0,   pk(1,0,0,0,1,0,420,210,8'h00)));
        bar_tbl.push_back(mkv("b1_one_pulse", 0, 0, 0, 0, 0, 0, 32'h0,   pk(1,0,0,0,0,0,420,210,8'h00)));
        bar_tbl.push_back(mkv("b2_wr1",       0, 0, 0, 0, 0, 1, 32'd100, pk(1,0,0,1,0,0,420,210,8'h00)));
        bar_tbl.push_back(mkv("b2_wr2",       0, 0, 0, 0, 0, 1, 32'd150, pk(1,0,0,1,0,0,420,210,8'h00)));
        bar_tbl.push_back(mkv("b2_overwrite", 0, 0, 1, 0, 0, 0, 32'h0,   pk(1,0,0,0,0,1,420,150,8'h00)));
        bar_tbl.push_back(mkv("b2_one_pulse", 0, 0, 0, 0, 0, 0, 32'h0,   pk(1,0,0,0,0,0,420,150,8'h00)));
        bar_tbl.push_back(mkv("ci_with_tick", 0, 0, 1, 0, 0, 1, 32'h232, pk(1,0,0,1,0,0,420,150,8'h00)));
        bar_tbl.push_back(mkv("held_pend",    0, 0, 0, 0, 0, 0, 32'h0,   pk(1,0,0,0,0,0,420,150,8'h00)));
        bar_tbl.push_back(mkv("held_apply",   0, 0, 1, 0, 0, 0, 32'h0,   pk(1,0,0,0,1,0,50,150,8'h00)));
        bar_tbl.push_back(mkv("held_idle",    0, 0, 0, 0, 0, 0, 32'h0,   pk(1,0,0,0,0,0,50,150,8'h00)));

        foreach (menu_tbl[i]) run_vec(menu_tbl[i]);
        serve_to_play(0, 8'h00, 210, 210);
        foreach (bar_tbl[i]) run_vec(bar_tbl[i]);

        // Player 2 takes three points; the match ends 0:3.
        for (int k = 1; k <= 3; k++) begin
            cyc("p2_point", 0, 0, 0, 0, 1, 0, 0, pk(1,1,0,0,0,0,50,150,8'(k << 4)));
            if (k < 3) begin
                cyc("post_point", 0, 0, 0, 0, 0, 0, 0, pk(1,1,0,0,0,0,50,150,8'(k << 4)));
                serve_to_play(0, 8'(k << 4), 50, 150);
            end else begin
                cyc("over", 0, 0, 0, 0, 0, 0, 0, pk(0,1,0,0,0,0,50,150,8'h30));
            end
        end
        cyc("over_pt_ign",  0, 0, 0, 1, 0, 0, 0,       pk(0,1,0,0,0,0,50,150,8'h30));
        cyc("over_ci_done", 0, 0, 0, 0, 0, 1, 32'h24D, pk(0,1,0,1,0,0,50,150,8'h30));
        cyc("over_no_pend", 0, 0, 1, 0, 0, 0, 0,       pk(0,1,0,0,0,0,50,150,8'h30));
        cyc("restart",      0, 1, 0, 0, 0, 0, 0,       pk(1,1,0,0,0,0,210,210,8'h00));
        serve_to_play(0, 8'h00, 210, 210);

        cyc("same_cyc_p1",  0, 0, 0, 1, 1, 0, 0, pk(1,1,1,0,0,0,210,210,8'h01));
        cyc("post_p1",      0, 0, 0, 0, 0, 0, 0, pk(1,1,1,0,0,0,210,210,8'h01));
        cyc("serve_pt_ign", 0, 0, 0, 0, 1, 0, 0, pk(1,1,1,0,0,0,210,210,8'h01));
        serve_to_play(1, 8'h01, 210, 210);
        cyc("p1_second",    0, 0, 0, 1, 0, 0, 0, pk(1,1,1,0,0,0,210,210,8'h02));
        cyc("post_p1b",     0, 0, 0, 0, 0, 0, 0, pk(1,1,1,0,0,0,210,210,8'h02));
        serve_to_play(1, 8'h02, 210, 210);
        cyc("b1_wr_play",   0, 0, 0, 0, 0, 1, 32'h34D, pk(1,0,1,1,0,0,210,210,8'h02));
        cyc("b1_apply",     0, 0, 1, 0, 0, 0, 0,       pk(1,0,1,0,1,0,333,210,8'h02));
        cyc("p2_point_b",   0, 0, 0, 0, 1, 0, 0,       pk(1,1,0,0,0,0,333,210,8'h12));
        cyc("post_p2b",     0, 0, 0, 0, 0, 0, 0,       pk(1,1,0,0,0,0,333,210,8'h12));
        serve_to_play(0, 8'h12, 333, 210);
        cyc("rst_mid_play", 1, 0, 1, 1, 0, 1, 32'h3FF, pk(0,1,0,0,0,0,210,210,8'h00));
        check("result_hi", {8'b0, result[31:8]}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
